// File: rtl/i2c_arb_pkg.sv
// Shared state encoding, status codes and small helpers for the I2C bus arbiter.
package i2c_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_ISSUE      = 3'd1,
        S_WAIT_RSP   = 3'd2,
        S_WAIT_STOP  = 3'd3,
        S_ABORT_STOP = 3'd4
    } state_e;

    localparam logic [1:0] ST_ACK   = 2'b00;
    localparam logic [1:0] ST_RDATA = 2'b01;
    localparam logic [1:0] ST_NACK  = 2'b10;
    localparam logic [1:0] ST_ERR   = 2'b11;

    function automatic logic [1:0] idx_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    function automatic logic [7:0] sel_byte(input logic [15:0] data, input logic idx);
        return idx ? data[15:8] : data[7:0];
    endfunction

endpackage

// File: rtl/i2c_bus_arbiter_if.sv
// Requester-side and I2C-master-side signal bundle of i2c_bus_arbiter.
// Modport master is the arbiter's view; modport slave is the requesters plus byte-level master.
interface i2c_bus_arbiter_if ();

    logic [1:0]  req_valid;
    logic [1:0]  req_start;
    logic [1:0]  req_stop;
    logic [1:0]  req_rw;
    logic [15:0] req_data;
    logic [1:0]  req_ready;
    logic [1:0]  req_done;
    logic [1:0]  req_status;
    logic [7:0]  req_rdata;

    logic        m_go;
    logic        m_start;
    logic        m_stop;
    logic        m_rw;
    logic [7:0]  m_data_w;
    logic        m_ack;
    logic        m_ack_r;
    logic        m_nack;
    logic        m_timeout;
    logic        m_busy;
    logic [7:0]  m_data_r;

    modport master (
        input  req_valid, req_start, req_stop, req_rw, req_data,
        input  m_ack, m_ack_r, m_nack, m_timeout, m_busy, m_data_r,
        output req_ready, req_done, req_status, req_rdata,
        output m_go, m_start, m_stop, m_rw, m_data_w
    );

    modport slave (
        output req_valid, req_start, req_stop, req_rw, req_data,
        output m_ack, m_ack_r, m_nack, m_timeout, m_busy, m_data_r,
        input  req_ready, req_done, req_status, req_rdata,
        input  m_go, m_start, m_stop, m_rw, m_data_w
    );

endinterface

// File: rtl/i2c_arb_rr.sv
// Two-way round-robin picker: one-hot winner among eligible requesters.
module i2c_arb_rr (
    input  logic [1:0] eligible,
    input  logic       last,
    output logic [1:0] pick
);

    // On a tie, the requester that was not served last wins.
    always_comb begin
        pick = 2'b00;
        case (eligible)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last ? 2'b01 : 2'b10;
            default: pick = 2'b00;
        endcase
    end

endmodule

// File: rtl/i2c_bus_arbiter.sv
// Shares one byte-level I2C master between two requesters, locking the bus from START to STOP.
// Optional lock watchdog is built when I2C_ARB_WATCHDOG_EN is defined.
module i2c_bus_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 100000
) (
    input  logic              clock,
    input  logic              reset_n,
    i2c_bus_arbiter_if.master bus,
    output logic [1:0]        grant,
    output logic              wd_expired
);

    state_e      state_q, state_d;
    logic        lock_q, lock_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [1:0]  err_q, err_d;
    logic [1:0]  ready_q, ready_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  status_q, status_d;
    logic [7:0]  rdata_q, rdata_d;
    logic        go_q, go_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        rw_q, rw_d;
    logic [7:0]  data_q, data_d;

    logic [1:0]  elig_s, bad_s, pick_s, bad_pick_s, own_valid_s;
    logic        accept_s, sel_s, wd_fire_s;

    assign elig_s      = bus.req_valid & bus.req_start;
    assign bad_s       = bus.req_valid & ~bus.req_start;
    assign own_valid_s = bus.req_valid & grant_q;

    i2c_arb_rr u_rr_start (.eligible(elig_s), .last(last_q), .pick(pick_s));
    i2c_arb_rr u_rr_err   (.eligible(bad_s),  .last(last_q), .pick(bad_pick_s));

    // Next-state, command latching and response routing.
    always_comb begin
        state_d  = state_q;
        lock_d   = lock_q;
        grant_d  = grant_q;
        last_d   = last_q;
        err_d    = 2'b00;
        ready_d  = 2'b00;
        done_d   = 2'b00;
        status_d = status_q;
        rdata_d  = rdata_q;
        go_d     = 1'b0;
        start_d  = start_q;
        stop_d   = stop_q;
        rw_d     = rw_q;
        data_d   = data_q;
        accept_s = 1'b0;
        sel_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (err_q != 2'b00) begin
                    done_d   = err_q;
                    status_d = ST_ERR;
                end else if (lock_q) begin
                    if (wd_fire_s) begin
                        go_d    = 1'b1;
                        start_d = 1'b0;
                        stop_d  = 1'b1;
                        state_d = S_ABORT_STOP;
                    end else if (own_valid_s != 2'b00) begin
                        accept_s = 1'b1;
                        sel_s    = grant_q[1];
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (pick_s != 2'b00) begin
                    accept_s = 1'b1;
                    sel_s    = pick_s[1];
                    grant_d  = pick_s;
                end else if (bad_pick_s != 2'b00) begin
                    // A byte without START on a free bus is refused without touching the master.
                    ready_d = bad_pick_s;
                    err_d   = bad_pick_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                go_d    = 1'b1;
                state_d = stop_q ? S_WAIT_STOP : S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (bus.m_nack) begin
                    done_d   = grant_q;
                    status_d = ST_NACK;
                    go_d     = 1'b1;
                    start_d  = 1'b0;
                    stop_d   = 1'b1;
                    state_d  = S_ABORT_STOP;
                end else if (bus.m_timeout) begin
                    done_d   = grant_q;
                    status_d = ST_ERR;
                    go_d     = 1'b1;
                    start_d  = 1'b0;
                    stop_d   = 1'b1;
                    state_d  = S_ABORT_STOP;
                end else if (bus.m_ack_r) begin
                    done_d   = grant_q;
                    status_d = ST_RDATA;
                    rdata_d  = bus.m_data_r;
                    state_d  = S_IDLE;
                end else if (bus.m_ack) begin
                    done_d   = grant_q;
                    status_d = ST_ACK;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_STOP, S_ABORT_STOP: begin
                // m_busy is ignored while our own m_go is still on the wire.
                if (!go_q && !bus.m_busy) begin
                    lock_d  = 1'b0;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                    state_d = S_IDLE;
                    if (state_q == S_WAIT_STOP) begin
                        done_d   = grant_q;
                        status_d = ST_ACK;
                    end else begin
                        done_d = 2'b00;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (accept_s) begin
            ready_d = idx_onehot(sel_s);
            start_d = bus.req_start[sel_s];
            stop_d  = bus.req_stop[sel_s];
            rw_d    = bus.req_rw[sel_s] & ~bus.req_stop[sel_s];
            data_d  = bus.req_stop[sel_s] ? 8'h00 : sel_byte(bus.req_data, sel_s);
            lock_d  = lock_q | bus.req_start[sel_s];
            state_d = S_ISSUE;
        end else begin
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            lock_q   <= 1'b0;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            err_q    <= 2'b00;
            ready_q  <= 2'b00;
            done_q   <= 2'b00;
            status_q <= 2'b00;
            rdata_q  <= 8'h00;
            go_q     <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
            go_q     <= go_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            rw_q     <= rw_d;
            data_q   <= data_d;
        end
    end

`ifdef I2C_ARB_WATCHDOG_EN
    localparam int unsigned WD_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wd_idle_s, wd_q;

    // Count owner-silent IDLE cycles while the bus is locked.
    always_comb begin
        wd_idle_s = lock_q && (state_q == S_IDLE) && (own_valid_s == 2'b00);
        wd_fire_s = wd_idle_s && (wd_cnt_q == WD_W'(LOCK_TIMEOUT - 1));
        if (wd_idle_s && !wd_fire_s) begin
            wd_cnt_d = wd_cnt_q + WD_W'(1);
        end else begin
            wd_cnt_d = WD_W'(0);
        end
    end

    // Watchdog counter and expiry pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt_q <= WD_W'(0);
            wd_q     <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            wd_q     <= wd_fire_s;
        end
    end

    assign wd_expired = wd_q;
`else
    assign wd_fire_s  = 1'b0;
    assign wd_expired = 1'b0 & (LOCK_TIMEOUT == 0);
`endif

    assign grant          = grant_q;
    assign bus.req_ready  = ready_q;
    assign bus.req_done   = done_q;
    assign bus.req_status = status_q;
    assign bus.req_rdata  = rdata_q;
    assign bus.m_go       = go_q;
    assign bus.m_start    = start_q;
    assign bus.m_stop     = stop_q;
    assign bus.m_rw       = rw_q;
    assign bus.m_data_w   = data_q;

endmodule
